// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the request/response handshake and the Avalon-MM data-bus signals
// of the load/store unit.
//
// Request side (driven by the execute stage):
//   req_valid, opcode, addr, wdata        -> into the unit
//   req_ready                             <- unit idle
// Response side:
//   resp_valid, resp_data, resp_misaligned <- one-cycle result pulse
// Avalon-MM data bus:
//   avm_address, avm_read, avm_write,
//   avm_byteenable, avm_writedata          <- driven by the unit
//   avm_readdata, avm_waitrequest          -> returned by the bus slave
//
// Modports:
//   slave  : view of the load/store unit itself
//   master : view of its environment (requester plus Avalon slave)
// -----------------------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [5:0]            opcode;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;

    logic                  resp_valid;
    logic [31:0]           resp_data;
    logic                  resp_misaligned;

    logic [ADDR_WIDTH-1:0] avm_address;
    logic                  avm_read;
    logic                  avm_write;
    logic [3:0]            avm_byteenable;
    logic [31:0]           avm_writedata;
    logic [31:0]           avm_readdata;
    logic                  avm_waitrequest;

    modport slave (
        input  req_valid, opcode, addr, wdata,
        output req_ready,
        output resp_valid, resp_data, resp_misaligned,
        output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport master (
        output req_valid, opcode, addr, wdata,
        input  req_ready,
        input  resp_valid, resp_data, resp_misaligned,
        input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Load/store datapath between the MIPS execute stage and an Avalon-MM data
// bus. Stores get a word-aligned address, byte enables and lane-replicated
// write data; loads wait out waitrequest, then pick the addressed byte or
// halfword and sign/zero-extend it to 32 bits. One request in flight at a time.
//
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : mem_access_unit_if.slave (request, response and Avalon signals)
//
// Every output is a register. Latency from the accept edge (cycle 0):
//   bus strobe in cycle 1, resp_valid in cycle 2 plus one per waitrequest
//   cycle; faulting or unsupported requests respond in cycle 1 with no strobe.
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    mem_access_unit_if.slave bus
);

    // MIPS primary opcodes of the supported loads and stores
    localparam logic [5:0] OPCODE_LB  = 6'h20;
    localparam logic [5:0] OPCODE_LH  = 6'h21;
    localparam logic [5:0] OPCODE_LW  = 6'h23;
    localparam logic [5:0] OPCODE_LBU = 6'h24;
    localparam logic [5:0] OPCODE_LHU = 6'h25;
    localparam logic [5:0] OPCODE_SB  = 6'h28;
    localparam logic [5:0] OPCODE_SH  = 6'h29;
    localparam logic [5:0] OPCODE_SW  = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Opcode decode helpers
    // ------------------------------------------------------------------
    function automatic logic f_supported(input logic [5:0] op);
        case (op)
            OPCODE_LB, OPCODE_LBU, OPCODE_LH, OPCODE_LHU, OPCODE_LW,
            OPCODE_SB, OPCODE_SH, OPCODE_SW: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    function automatic logic f_is_load(input logic [5:0] op);
        case (op)
            OPCODE_LB, OPCODE_LBU, OPCODE_LH, OPCODE_LHU, OPCODE_LW: return 1'b1;
            default:                                                 return 1'b0;
        endcase
    endfunction

    function automatic logic f_misaligned(input logic [5:0] op, input logic [1:0] lane);
        case (op)
            OPCODE_LH, OPCODE_LHU, OPCODE_SH: return lane[0];
            OPCODE_LW, OPCODE_SW:             return |lane;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] f_byteenable(input logic [5:0] op, input logic [1:0] lane);
        case (op)
            OPCODE_SB: return 4'b0001 << lane;
            OPCODE_SH: return lane[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;   // loads and SW read/write the full word
        endcase
    endfunction

    // Replicating across lanes lets the slave pick the data up from whichever
    // lane the byte enables select, without any shifting here.
    function automatic logic [31:0] f_store_data(input logic [5:0] op, input logic [31:0] wd);
        case (op)
            OPCODE_SB: return {4{wd[7:0]}};
            OPCODE_SH: return {2{wd[15:0]}};
            default:   return wd;
        endcase
    endfunction

    function automatic logic [31:0] f_load_extend(input logic [5:0]  op,
                                                  input logic [1:0]  lane,
                                                  input logic [31:0] rd);
        logic        [31:0] shifted;
        logic signed [7:0]  sel_byte;
        logic signed [15:0] sel_half;
        logic signed [31:0] ext;
        shifted  = rd >> {lane, 3'b000};
        sel_byte = signed'(shifted[7:0]);
        sel_half = signed'(lane[1] ? rd[31:16] : rd[15:0]);
        ext      = signed'(rd);
        case (op)
            OPCODE_LB:  ext = sel_byte;                          // sign-extending assignment
            OPCODE_LBU: ext = signed'({24'd0, sel_byte});
            OPCODE_LH:  ext = sel_half;
            OPCODE_LHU: ext = signed'({16'd0, sel_half});
            default:    ext = signed'(rd);
        endcase
        return unsigned'(ext);
    endfunction

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t                r_state,           w_state_nxt;
    logic                  r_req_ready,       w_req_ready_nxt;
    logic                  r_resp_valid,      w_resp_valid_nxt;
    logic                  r_resp_misaligned, w_resp_misaligned_nxt;
    logic [31:0]           r_resp_data,       w_resp_data_nxt;
    logic [ADDR_WIDTH-1:0] r_avm_address,     w_avm_address_nxt;
    logic                  r_avm_read,        w_avm_read_nxt;
    logic                  r_avm_write,       w_avm_write_nxt;
    logic [3:0]            r_avm_be,          w_avm_be_nxt;
    logic [31:0]           r_avm_wdata,       w_avm_wdata_nxt;
    logic [5:0]            r_op,              w_op_nxt;
    logic [1:0]            r_lane,            w_lane_nxt;

    logic [1:0]            w_req_lane;
    logic                  w_req_fault;
    logic                  w_req_supported;

    assign w_req_lane      = bus.addr[1:0];
    assign w_req_supported = f_supported(bus.opcode);
    assign w_req_fault     = f_misaligned(bus.opcode, w_req_lane);

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt           = r_state;
        w_req_ready_nxt       = r_req_ready;
        w_resp_valid_nxt      = r_resp_valid;
        w_resp_misaligned_nxt = r_resp_misaligned;
        w_resp_data_nxt       = r_resp_data;
        w_avm_address_nxt     = r_avm_address;
        w_avm_read_nxt        = r_avm_read;
        w_avm_write_nxt       = r_avm_write;
        w_avm_be_nxt          = r_avm_be;
        w_avm_wdata_nxt       = r_avm_wdata;
        w_op_nxt              = r_op;
        w_lane_nxt            = r_lane;

        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_req_ready_nxt = 1'b0;
                    if (!w_req_supported || w_req_fault) begin
                        // No bus access: answer straight away
                        w_resp_valid_nxt      = 1'b1;
                        w_resp_misaligned_nxt = w_req_fault;
                        w_resp_data_nxt       = 32'd0;
                        w_state_nxt           = S_RESP;
                    end else begin
                        w_op_nxt          = bus.opcode;
                        w_lane_nxt        = w_req_lane;
                        w_avm_address_nxt = {bus.addr[ADDR_WIDTH-1:2], 2'b00};
                        w_avm_read_nxt    = f_is_load(bus.opcode);
                        w_avm_write_nxt   = !f_is_load(bus.opcode);
                        w_avm_be_nxt      = f_byteenable(bus.opcode, w_req_lane);
                        w_avm_wdata_nxt   = f_store_data(bus.opcode, bus.wdata);
                        w_state_nxt       = S_BUS;
                    end
                end
            end

            S_BUS: begin
                // Bus fields stay frozen until the slave stops stalling
                if (!bus.avm_waitrequest) begin
                    w_avm_read_nxt        = 1'b0;
                    w_avm_write_nxt       = 1'b0;
                    w_resp_valid_nxt      = 1'b1;
                    w_resp_misaligned_nxt = 1'b0;
                    w_resp_data_nxt       = f_is_load(r_op)
                                          ? f_load_extend(r_op, r_lane, bus.avm_readdata)
                                          : 32'd0;
                    w_state_nxt           = S_RESP;
                end
            end

            S_RESP: begin
                w_resp_valid_nxt      = 1'b0;
                w_resp_misaligned_nxt = 1'b0;
                w_req_ready_nxt       = 1'b1;
                w_state_nxt           = S_IDLE;
            end

            default: begin
                w_avm_read_nxt   = 1'b0;
                w_avm_write_nxt  = 1'b0;
                w_resp_valid_nxt = 1'b0;
                w_req_ready_nxt  = 1'b1;
                w_state_nxt      = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state           <= S_IDLE;
            r_req_ready       <= 1'b1;
            r_resp_valid      <= 1'b0;
            r_resp_misaligned <= 1'b0;
            r_resp_data       <= 32'd0;
            r_avm_address     <= '0;
            r_avm_read        <= 1'b0;
            r_avm_write       <= 1'b0;
            r_avm_be          <= 4'd0;
            r_avm_wdata       <= 32'd0;
            r_op              <= 6'd0;
            r_lane            <= 2'd0;
        end else begin
            r_state           <= w_state_nxt;
            r_req_ready       <= w_req_ready_nxt;
            r_resp_valid      <= w_resp_valid_nxt;
            r_resp_misaligned <= w_resp_misaligned_nxt;
            r_resp_data       <= w_resp_data_nxt;
            r_avm_address     <= w_avm_address_nxt;
            r_avm_read        <= w_avm_read_nxt;
            r_avm_write       <= w_avm_write_nxt;
            r_avm_be          <= w_avm_be_nxt;
            r_avm_wdata       <= w_avm_wdata_nxt;
            r_op              <= w_op_nxt;
            r_lane            <= w_lane_nxt;
        end
    end

    assign bus.req_ready       = r_req_ready;
    assign bus.resp_valid      = r_resp_valid;
    assign bus.resp_misaligned = r_resp_misaligned;
    assign bus.resp_data       = r_resp_data;
    assign bus.avm_address     = r_avm_address;
    assign bus.avm_read        = r_avm_read;
    assign bus.avm_write       = r_avm_write;
    assign bus.avm_byteenable  = r_avm_be;
    assign bus.avm_writedata   = r_avm_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit: loads with sign/zero extension, stores
// with byte enables and lane replication, waitrequest stalls, alignment faults,
// unsupported opcodes, reset during an access and back-to-back requests.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int ADDR_WIDTH = 32;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    mem_access_unit #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE; returns in cycle 1 (after the accept edge)
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid = 1'b1;
        bus.opcode    = op;
        bus.addr      = a;
        bus.wdata     = wd;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic load_case(input string tag, input logic [5:0] op, input logic [31:0] a,
                             input logic [31:0] rd, input logic [31:0] exp_addr,
                             input logic [31:0] exp_data);
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = rd;
        issue(op, a, 32'hDEAD_0000);
        chk1({tag, ".c1_read"},  bus.avm_read, 1'b1);
        chk1({tag, ".c1_write"}, bus.avm_write, 1'b0);
        chk ({tag, ".c1_addr"},  bus.avm_address, exp_addr);
        chk ({tag, ".c1_be"},    {28'd0, bus.avm_byteenable}, 32'h0000_000F);
        chk1({tag, ".c1_ready"}, bus.req_ready, 1'b0);
        chk1({tag, ".c1_rvld"},  bus.resp_valid, 1'b0);
        tick();
        chk1({tag, ".c2_rvld"},  bus.resp_valid, 1'b1);
        chk ({tag, ".c2_data"},  bus.resp_data, exp_data);
        chk1({tag, ".c2_mis"},   bus.resp_misaligned, 1'b0);
        chk1({tag, ".c2_read"},  bus.avm_read, 1'b0);
        tick();
        chk1({tag, ".c3_rvld"},  bus.resp_valid, 1'b0);
        chk1({tag, ".c3_ready"}, bus.req_ready, 1'b1);
    endtask

    task automatic store_case(input string tag, input logic [5:0] op, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd);
        bus.avm_waitrequest = 1'b0;
        issue(op, a, wd);
        chk1({tag, ".c1_write"}, bus.avm_write, 1'b1);
        chk1({tag, ".c1_read"},  bus.avm_read, 1'b0);
        chk ({tag, ".c1_addr"},  bus.avm_address, exp_addr);
        chk ({tag, ".c1_be"},    {28'd0, bus.avm_byteenable}, {28'd0, exp_be});
        chk ({tag, ".c1_wd"},    bus.avm_writedata, exp_wd);
        tick();
        chk1({tag, ".c2_rvld"},  bus.resp_valid, 1'b1);
        chk ({tag, ".c2_data"},  bus.resp_data, 32'd0);
        chk1({tag, ".c2_write"}, bus.avm_write, 1'b0);
        tick();
        chk1({tag, ".c3_ready"}, bus.req_ready, 1'b1);
    endtask

    task automatic fault_case(input string tag, input logic [5:0] op, input logic [31:0] a,
                              input logic exp_mis);
        bus.avm_waitrequest = 1'b0;
        issue(op, a, 32'h5555_AAAA);
        chk1({tag, ".c1_rvld"},  bus.resp_valid, 1'b1);
        chk1({tag, ".c1_mis"},   bus.resp_misaligned, exp_mis);
        chk ({tag, ".c1_data"},  bus.resp_data, 32'd0);
        chk1({tag, ".c1_read"},  bus.avm_read, 1'b0);
        chk1({tag, ".c1_write"}, bus.avm_write, 1'b0);
        tick();
        chk1({tag, ".c2_rvld"},  bus.resp_valid, 1'b0);
        chk1({tag, ".c2_mis"},   bus.resp_misaligned, 1'b0);
        chk1({tag, ".c2_ready"}, bus.req_ready, 1'b1);
        chk1({tag, ".c2_read"},  bus.avm_read, 1'b0);
        chk1({tag, ".c2_write"}, bus.avm_write, 1'b0);
    endtask

    logic [3:0]  sb_be_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [31:0] lb_exp_tab[4] = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80};

    initial begin
        logic is_ld;

        reset_n             = 1'b0;
        bus.req_valid       = 1'b0;
        bus.opcode          = 6'd0;
        bus.addr            = 32'd0;
        bus.wdata           = 32'd0;
        bus.avm_readdata    = 32'd0;
        bus.avm_waitrequest = 1'b0;
        tick();
        tick();

        // Reset state
        chk1("rst.ready", bus.req_ready, 1'b1);
        chk1("rst.rvld",  bus.resp_valid, 1'b0);
        chk1("rst.mis",   bus.resp_misaligned, 1'b0);
        chk1("rst.read",  bus.avm_read, 1'b0);
        chk1("rst.write", bus.avm_write, 1'b0);
        chk ("rst.data",  bus.resp_data, 32'd0);
        chk ("rst.addr",  bus.avm_address, 32'd0);
        chk ("rst.wd",    bus.avm_writedata, 32'd0);
        chk ("rst.be",    {28'd0, bus.avm_byteenable}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Byte loads with sign and zero extension
        load_case("lb",  OP_LB,  32'h0000_1002, 32'h00A5_0000, 32'h0000_1000, 32'hFFFF_FFA5);
        load_case("lbu", OP_LBU, 32'h0000_1002, 32'h00A5_0000, 32'h0000_1000, 32'h0000_00A5);
        load_case("lh",  OP_LH,  32'h0000_1102, 32'h8001_7FFF, 32'h0000_1100, 32'hFFFF_8001);

        // Alignment faults (previous resp_data is nonzero)
        fault_case("lw_mis", OP_LW, 32'h0000_3001, 1'b1);
        fault_case("sh_mis", OP_SH, 32'h0000_3003, 1'b1);

        // Halfword store stalled by three waitrequest cycles
        bus.avm_waitrequest = 1'b1;
        issue(OP_SH, 32'h0000_2002, 32'h1234_BEEF);
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) bus.avm_waitrequest = 1'b0;
            chk1($sformatf("sh.c%0d_write", c), bus.avm_write, 1'b1);
            chk ($sformatf("sh.c%0d_addr", c),  bus.avm_address, 32'h0000_2000);
            chk ($sformatf("sh.c%0d_be", c),    {28'd0, bus.avm_byteenable}, 32'h0000_000C);
            chk ($sformatf("sh.c%0d_wd", c),    bus.avm_writedata, 32'hBEEF_BEEF);
            chk1($sformatf("sh.c%0d_rvld", c),  bus.resp_valid, 1'b0);
            tick();
        end
        chk1("sh.c5_rvld",  bus.resp_valid, 1'b1);
        chk ("sh.c5_data",  bus.resp_data, 32'd0);
        chk1("sh.c5_write", bus.avm_write, 1'b0);
        tick();
        chk1("sh.c6_ready", bus.req_ready, 1'b1);

        // Every byte lane: SB enables/replication, LB extraction
        for (int k = 0; k < 4; k++) begin
            store_case($sformatf("sb%0d", k), OP_SB, 32'h0000_0500 + k, 32'hAABB_CC5A,
                       32'h0000_0500, sb_be_tab[k], 32'h5A5A_5A5A);
        end
        for (int k = 0; k < 4; k++) begin
            load_case($sformatf("lb%0d", k), OP_LB, 32'h0000_0600 + k, 32'h80FF_7F01,
                      32'h0000_0600, lb_exp_tab[k]);
        end
        store_case("sw", OP_SW, 32'h0000_0704, 32'h0102_0304, 32'h0000_0704, 4'b1111, 32'h0102_0304);

        // Reset in the middle of a stalled load
        bus.avm_waitrequest = 1'b1;
        issue(OP_LW, 32'h0000_4100, 32'd0);
        chk1("rmid.c1_read", bus.avm_read, 1'b1);
        tick();
        chk1("rmid.c2_read", bus.avm_read, 1'b1);
        reset_n = 1'b0;
        tick();
        chk1("rmid.c3_read",  bus.avm_read, 1'b0);
        chk1("rmid.c3_ready", bus.req_ready, 1'b1);
        chk1("rmid.c3_rvld",  bus.resp_valid, 1'b0);
        chk ("rmid.c3_data",  bus.resp_data, 32'd0);
        reset_n             = 1'b1;
        bus.avm_waitrequest = 1'b0;
        tick();
        chk1("rmid.c4_rvld", bus.resp_valid, 1'b0);
        chk1("rmid.c4_read", bus.avm_read, 1'b0);
        load_case("lw_after_rst", OP_LW, 32'h0000_4000, 32'hCAFE_F00D, 32'h0000_4000, 32'hCAFE_F00D);

        // Back-to-back with req_valid held high: SW, LW, SW, LW
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = 32'h1357_2468;
        bus.req_valid       = 1'b1;
        bus.opcode          = OP_SW;
        bus.addr            = 32'h0000_0800;
        bus.wdata           = 32'h1122_3344;
        for (int r = 0; r < 4; r++) begin
            is_ld = ((r % 2) == 1);
            tick();
            chk1($sformatf("b2b%0d.c1_ready", r), bus.req_ready, 1'b0);
            chk1($sformatf("b2b%0d.c1_read", r),  bus.avm_read, is_ld);
            chk1($sformatf("b2b%0d.c1_write", r), bus.avm_write, !is_ld);
            chk ($sformatf("b2b%0d.c1_addr", r),  bus.avm_address,
                 is_ld ? 32'h0000_0900 : 32'h0000_0800);
            // Change the pending request while busy; it must wait for IDLE
            bus.opcode = is_ld ? OP_SW : OP_LW;
            bus.addr   = is_ld ? 32'h0000_0800 : 32'h0000_0900;
            if (r == 3) bus.req_valid = 1'b0;
            tick();
            chk1($sformatf("b2b%0d.c2_rvld", r),  bus.resp_valid, 1'b1);
            chk1($sformatf("b2b%0d.c2_ready", r), bus.req_ready, 1'b0);
            chk ($sformatf("b2b%0d.c2_data", r),  bus.resp_data,
                 is_ld ? 32'h1357_2468 : 32'd0);
            tick();
            chk1($sformatf("b2b%0d.c3_rvld", r),  bus.resp_valid, 1'b0);
            chk1($sformatf("b2b%0d.c3_ready", r), bus.req_ready, 1'b1);
        end
        tick();
        chk1("b2b.end_ready", bus.req_ready, 1'b1);
        chk1("b2b.end_read",  bus.avm_read, 1'b0);
        chk1("b2b.end_write", bus.avm_write, 1'b0);

        // Unsupported opcode (previous resp_data is nonzero)
        load_case("lw_pre", OP_LW, 32'h0000_0A00, 32'h7777_0001, 32'h0000_0A00, 32'h7777_0001);
        fault_case("unsup", 6'h0F, 32'h0000_0B00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
